// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: latches the decoder's control bits and steps them through
// fetch/decode/exec/mem/wb/branch as per-cycle datapath strobes. Optional SEQ_PERF_COUNT_EN adds perf counters.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    input  logic        reg_read,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        branch,
    input  logic        mem_to_reg,
    input  logic        alu_src,
    input  logic        pc_src,
    input  logic        branch_cond,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_load,
    output logic        rf_read_en,
    output logic        alu_start,
    output logic        alu_src_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_write_en,
    output logic        wb_sel,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        busy,
    output logic        fault,
    output logic [2:0]  state
`ifdef SEQ_PERF_COUNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] retired_count
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    typedef struct packed {
        logic reg_read;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic mem_to_reg;
        logic alu_src;
        logic pc_src;
    } ctrl_t;

    state_t        state_q, state_d;
    ctrl_t         ctrl_q, ctrl_d, ctrl_in;
    logic [CW-1:0] tmo_q, tmo_d;
    logic          st_done_q, st_done_d;
    logic          ir_load_q, ir_load_d;
    logic          eoi;
    logic          taken;

    assign ctrl_in = {reg_read, reg_write, mem_read, mem_write,
                      branch, mem_to_reg, alu_src, pc_src};

    // Branches without a register read are unconditional.
    assign taken = ctrl_q.pc_src & (~ctrl_q.reg_read | branch_cond);

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        tmo_d       = tmo_q;
        st_done_d   = 1'b0;
        ir_load_d   = 1'b0;
        eoi         = 1'b0;
        imem_req    = 1'b0;
        rf_read_en  = 1'b0;
        alu_start   = 1'b0;
        alu_src_sel = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_write_en = 1'b0;
        wb_sel      = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load_d = 1'b1;
                    state_d   = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DECODE: begin
                ctrl_d = ctrl_in;
                if (mem_read && mem_write)  state_d = S_FAULT;
                else if (ctrl_in == '0)     eoi     = 1'b1;
                else                        state_d = S_EXEC;
            end
            S_EXEC: begin
                rf_read_en  = ctrl_q.reg_read;
                alu_start   = 1'b1;
                alu_src_sel = ctrl_q.alu_src;
                if (ctrl_q.mem_read || ctrl_q.mem_write)       state_d = S_MEM;
                else if (ctrl_q.branch)                        state_d = S_BRANCH;
                else if (ctrl_q.reg_write || ctrl_q.mem_to_reg) state_d = S_WB;
                else                                           eoi     = 1'b1;
            end
            S_MEM: begin
                // A completed store spends one extra MEM cycle, request dropped, to retire.
                if (st_done_q) begin
                    eoi = 1'b1;
                end else begin
                    dmem_req = 1'b1;
                    dmem_we  = ctrl_q.mem_write;
                    if (dmem_ack) begin
                        if (ctrl_q.mem_read) state_d   = S_WB;
                        else                 st_done_d = 1'b1;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = S_FAULT;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            S_WB: begin
                rf_write_en = 1'b1;
                wb_sel      = ctrl_q.mem_to_reg;
                eoi         = 1'b1;
            end
            S_BRANCH: begin
                pc_write = 1'b1;
                pc_sel   = taken;
                state_d  = halt_req ? S_IDLE : S_FETCH;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        if (eoi) begin
            pc_write = 1'b1;
            pc_sel   = 1'b0;
            state_d  = halt_req ? S_IDLE : S_FETCH;
        end

        if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) tmo_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            tmo_q     <= '0;
            st_done_q <= 1'b0;
            ir_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            tmo_q     <= tmo_d;
            st_done_q <= st_done_d;
            ir_load_q <= ir_load_d;
        end
    end

    assign ir_load = ir_load_q;
    assign busy    = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign fault   = (state_q == S_FAULT);
    assign state   = state_q;

`ifdef SEQ_PERF_COUNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + (busy ? 32'd1 : 32'd0);
        retired_cnt_d = retired_cnt_q + (pc_write ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign cycle_count   = cycle_cnt_q;
    assign retired_count = retired_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (MEM_TIMEOUT=4): reset, ALU, load, branches,
// memory timeout, decode fault and NOP/halt, each with hand-derived expected strobes.
module tb_multicycle_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, halt_req = 1'b0;
    logic reg_read = 1'b0, reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic branch = 1'b0, mem_to_reg = 1'b0, alu_src = 1'b0, pc_src = 1'b0;
    logic branch_cond = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic imem_req, ir_load, rf_read_en, alu_start, alu_src_sel, dmem_req, dmem_we;
    logic rf_write_en, wb_sel, pc_write, pc_sel, busy, fault;
    logic [2:0] state;
`ifdef SEQ_PERF_COUNT_EN
    logic [31:0] cycle_count, retired_count;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;
    int pcw_cnt = 0;
    int rfw_cnt = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .reg_read(reg_read), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .pc_src(pc_src),
        .branch_cond(branch_cond), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_load(ir_load), .rf_read_en(rf_read_en), .alu_start(alu_start),
        .alu_src_sel(alu_src_sel), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_write_en(rf_write_en), .wb_sel(wb_sel), .pc_write(pc_write), .pc_sel(pc_sel),
        .busy(busy), .fault(fault), .state(state)
`ifdef SEQ_PERF_COUNT_EN
        , .cycle_count(cycle_count), .retired_count(retired_count)
`endif
    );

    always @(posedge clk) begin
        if (pc_write)    pcw_cnt <= pcw_cnt + 1;
        if (rf_write_en) rfw_cnt <= rfw_cnt + 1;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Control bits: {reg_read, reg_write, mem_read, mem_write, branch, mem_to_reg, alu_src, pc_src}
    task automatic set_ctrl(input logic [7:0] c);
        {reg_read, reg_write, mem_read, mem_write, branch, mem_to_reg, alu_src, pc_src} = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0; halt_req = 1'b0; branch_cond = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        set_ctrl(8'h00);
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // From IDLE: start, zero-wait fetch; returns at the start of the DECODE cycle.
    task automatic issue(input logic [7:0] c);
        set_ctrl(c);
        start = 1'b1;
        cycle();
        start = 1'b0;
        imem_ack = 1'b1;
        cycle();
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        cycle(); cycle(); #2;
        vec_cnt++; if (state !== 3'd0) begin err_cnt++; $display("FAIL reset_state got=%0d exp=0", state); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vec_cnt++; if (fault !== 1'b0) begin err_cnt++; $display("FAIL reset_fault got=%b exp=0", fault); end
        vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL reset_imem_req got=%b exp=0", imem_req); end
        vec_cnt++; if (pc_write !== 1'b0) begin err_cnt++; $display("FAIL reset_pc_write got=%b exp=0", pc_write); end
        rst = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        #2;
        vec_cnt++; if (state !== 3'd1) begin err_cnt++; $display("FAIL start_state got=%0d exp=1", state); end
        vec_cnt++; if (imem_req !== 1'b1) begin err_cnt++; $display("FAIL start_imem_req got=%b exp=1", imem_req); end
        #1 rst = 1'b1;
        #1;
        vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL async_rst_imem_req got=%b exp=0", imem_req); end
        vec_cnt++; if (state !== 3'd0) begin err_cnt++; $display("FAIL async_rst_state got=%0d exp=0", state); end
        cycle();
        rst = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        #2;
        vec_cnt++; if (state !== 3'd1) begin err_cnt++; $display("FAIL restart_state got=%0d exp=1", state); end
    endtask

    task automatic test_alu();
        int pcw0, rfw0;
        do_reset();
        set_ctrl(8'hC0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        #2;
        pcw0 = pcw_cnt; rfw0 = rfw_cnt;
        vec_cnt++; if (state !== 3'd1) begin err_cnt++; $display("FAIL alu_fetch0 state=%0d exp=1", state); end
        cycle(); imem_ack = 1'b1; #2;
        vec_cnt++; if (imem_req !== 1'b1) begin err_cnt++; $display("FAIL alu_fetch1 imem_req=%b exp=1", imem_req); end
        cycle(); imem_ack = 1'b0; #2;
        vec_cnt++; if (state !== 3'd2) begin err_cnt++; $display("FAIL alu_decode state=%0d exp=2", state); end
        vec_cnt++; if (ir_load !== 1'b1) begin err_cnt++; $display("FAIL alu_ir_load got=%b exp=1", ir_load); end
        cycle(); #2;
        vec_cnt++; if (state !== 3'd3) begin err_cnt++; $display("FAIL alu_exec state=%0d exp=3", state); end
        vec_cnt++; if ({alu_start, rf_read_en, alu_src_sel} !== 3'b110) begin err_cnt++; $display("FAIL alu_exec_strobes got=%b exp=110", {alu_start, rf_read_en, alu_src_sel}); end
        cycle(); #2;
        vec_cnt++; if (state !== 3'd5) begin err_cnt++; $display("FAIL alu_wb state=%0d exp=5", state); end
        vec_cnt++; if ({rf_write_en, wb_sel, pc_write, pc_sel} !== 4'b1010) begin err_cnt++; $display("FAIL alu_wb_strobes got=%b exp=1010", {rf_write_en, wb_sel, pc_write, pc_sel}); end
        cycle(); #2;
        vec_cnt++; if (state !== 3'd1) begin err_cnt++; $display("FAIL alu_next state=%0d exp=1", state); end
        vec_cnt++; if (pcw_cnt - pcw0 !== 1) begin err_cnt++; $display("FAIL alu_pc_write_count got=%0d exp=1", pcw_cnt - pcw0); end
        vec_cnt++; if (rfw_cnt - rfw0 !== 1) begin err_cnt++; $display("FAIL alu_rf_write_count got=%0d exp=1", rfw_cnt - rfw0); end
    endtask

    task automatic test_load();
        do_reset();
        issue(8'hA6);
        cycle(); #2;
        vec_cnt++; if (alu_src_sel !== 1'b1) begin err_cnt++; $display("FAIL load_alu_src_sel got=%b exp=1", alu_src_sel); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            dmem_ack = (i == 2);
            #2;
            vec_cnt++; if ({state, dmem_req, dmem_we} !== 5'b100_1_0) begin err_cnt++; $display("FAIL load_mem%0d state/req/we got=%b exp=10010", i, {state, dmem_req, dmem_we}); end
        end
        cycle(); dmem_ack = 1'b0; halt_req = 1'b1; #2;
        vec_cnt++; if (state !== 3'd5) begin err_cnt++; $display("FAIL load_wb state=%0d exp=5", state); end
        vec_cnt++; if ({rf_write_en, wb_sel, pc_write, pc_sel} !== 4'b1110) begin err_cnt++; $display("FAIL load_wb_strobes got=%b exp=1110", {rf_write_en, wb_sel, pc_write, pc_sel}); end
        cycle(); halt_req = 1'b0; #2;
        vec_cnt++; if (state !== 3'd0) begin err_cnt++; $display("FAIL load_halt state=%0d exp=0", state); end
    endtask

    task automatic test_branch(input string name, input logic [7:0] c, input logic cond, input logic exp_sel);
        do_reset();
        issue(c);
        cycle(); #2;
        vec_cnt++; if (state !== 3'd3) begin err_cnt++; $display("FAIL %s exec state=%0d exp=3", name, state); end
        cycle(); branch_cond = cond; halt_req = 1'b1; #2;
        vec_cnt++; if (state !== 3'd6) begin err_cnt++; $display("FAIL %s state=%0d exp=6", name, state); end
        vec_cnt++; if ({pc_write, pc_sel} !== {1'b1, exp_sel}) begin err_cnt++; $display("FAIL %s pc_write/pc_sel got=%b exp=%b", name, {pc_write, pc_sel}, {1'b1, exp_sel}); end
        cycle(); halt_req = 1'b0; branch_cond = 1'b0; #2;
        vec_cnt++; if ({state, busy} !== 4'b000_0) begin err_cnt++; $display("FAIL %s idle state/busy got=%b exp=0000", name, {state, busy}); end
    endtask

    task automatic test_timeout();
        do_reset();
        issue(8'h92);
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle(); #2;
            vec_cnt++; if ({state, dmem_req, dmem_we} !== 5'b100_1_1) begin err_cnt++; $display("FAIL tmo_wait%0d state/req/we got=%b exp=10011", i, {state, dmem_req, dmem_we}); end
        end
        cycle(); start = 1'b1; #2;
        vec_cnt++; if (state !== 3'd7) begin err_cnt++; $display("FAIL tmo_state got=%0d exp=7", state); end
        vec_cnt++; if ({fault, busy, dmem_req} !== 3'b100) begin err_cnt++; $display("FAIL tmo_fault/busy/req got=%b exp=100", {fault, busy, dmem_req}); end
        cycle(); cycle(); start = 1'b0; #2;
        vec_cnt++; if ({state, fault} !== 4'b111_1) begin err_cnt++; $display("FAIL tmo_sticky state/fault got=%b exp=1111", {state, fault}); end

        do_reset();
        issue(8'h92);
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            dmem_ack = (i == 3);
            #2;
            vec_cnt++; if ({state, dmem_req} !== 4'b100_1) begin err_cnt++; $display("FAIL late_ack_wait%0d state/req got=%b exp=1001", i, {state, dmem_req}); end
        end
        cycle(); dmem_ack = 1'b0; halt_req = 1'b1; #2;
        vec_cnt++; if ({state, dmem_req, pc_write, pc_sel, fault} !== 7'b100_0_1_0_0) begin err_cnt++; $display("FAIL late_ack_retire got=%b exp=1000100", {state, dmem_req, pc_write, pc_sel, fault}); end
        cycle(); halt_req = 1'b0; #2;
        vec_cnt++; if ({state, fault} !== 4'b000_0) begin err_cnt++; $display("FAIL late_ack_idle state/fault got=%b exp=0000", {state, fault}); end
    endtask

    task automatic test_decode_fault();
        do_reset();
        issue(8'h30);
        cycle(); #2;
        vec_cnt++; if ({state, fault, busy} !== 5'b111_1_0) begin err_cnt++; $display("FAIL decode_fault state/fault/busy got=%b exp=11110", {state, fault, busy}); end
    endtask

    task automatic test_nop_halt();
        int pcw0;
        do_reset();
        pcw0 = pcw_cnt;
        issue(8'h00);
        halt_req = 1'b1;
        #2;
        vec_cnt++; if (state !== 3'd2) begin err_cnt++; $display("FAIL nop_decode state=%0d exp=2", state); end
        vec_cnt++; if ({pc_write, pc_sel} !== 2'b10) begin err_cnt++; $display("FAIL nop_pc got=%b exp=10", {pc_write, pc_sel}); end
        cycle(); halt_req = 1'b0; #2;
        vec_cnt++; if ({state, busy, pc_write} !== 5'b000_0_0) begin err_cnt++; $display("FAIL nop_idle state/busy/pcw got=%b exp=00000", {state, busy, pc_write}); end
        vec_cnt++; if (pcw_cnt - pcw0 !== 1) begin err_cnt++; $display("FAIL nop_pc_write_count got=%0d exp=1", pcw_cnt - pcw0); end
`ifdef SEQ_PERF_COUNT_EN
        vec_cnt++; if (retired_count !== 32'd1) begin err_cnt++; $display("FAIL nop_retired_count got=%0d exp=1", retired_count); end
        vec_cnt++; if (cycle_count !== 32'd2) begin err_cnt++; $display("FAIL nop_cycle_count got=%0d exp=2", cycle_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_branch("br_cond_nt", 8'h89, 1'b0, 1'b0);
        test_branch("br_cond_t",  8'h89, 1'b1, 1'b1);
        test_branch("br_uncond",  8'h09, 1'b0, 1'b1);
        test_timeout();
        test_decode_fault();
        test_nop_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
